clk_gen_multi: RTL

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

---
 rtl/clk_gen_multi.sv | 135 +++++++++++++
 1 files changed

// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - multi-channel programmable clock generator; optional phase offset via CLK_GEN_PHASE_EN
module clk_gen_multi #(
  parameter logic [63:0] CLK_FREQUENCY = 64'd420000000,
  parameter logic [63:0] SECOND        = 64'd1000000000,
  parameter logic [63:0] UNIT          = SECOND / CLK_FREQUENCY,
  parameter int          CHANNELS      = 4,
  parameter int          RESOLUTION    = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS-1:0]            enable,
  input  logic [CHANNELS*RESOLUTION-1:0] half_period,
  input  logic [CHANNELS*RESOLUTION-1:0] phase,
  input  logic [CHANNELS-1:0]            load,
  input  logic                           sync,
  output logic [CHANNELS-1:0]            clk_out,
  output logic [CHANNELS-1:0]            overflow,
  output logic [CHANNELS-1:0]            pending
);

  localparam int W = RESOLUTION;
  // One extra bit so the increment can detect wrap-around and saturate.
  localparam logic [W:0] UNIT_EXT = (W+1)'(UNIT);

  logic [W-1:0] start_v [CHANNELS];

  logic [W-1:0] cnt_q [CHANNELS];
  logic [W-1:0] cnt_d [CHANNELS];
  logic [W-1:0] act_q [CHANNELS];
  logic [W-1:0] act_d [CHANNELS];
  logic [W-1:0] shd_q [CHANNELS];
  logic [W-1:0] shd_d [CHANNELS];
  logic [W:0]   sum   [CHANNELS];

  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] clk_out_q, clk_out_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  // Low for the first edge after reset release so that edge never toggles.
  logic armed_q, armed_d;

`ifdef CLK_GEN_PHASE_EN
  // Counter restart value comes from the per-channel phase offset.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      start_v[i] = phase[i*W +: W];
    end
  end
`else
  logic unused_phase;
  assign unused_phase = ^phase;

  // Without phase support every channel restarts its counter from zero.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      start_v[i] = '0;
    end
  end
`endif

  // Per-channel next state: sync beats disable beats normal counting; load applies last.
  always_comb begin
    armed_d   = 1'b1;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      act_d[i] = act_q[i];
      shd_d[i] = shd_q[i];
      sum[i]   = {1'b0, cnt_q[i]} + UNIT_EXT;
      if (armed_q) begin
        if (sync) begin
          cnt_d[i]     = start_v[i];
          clk_out_d[i] = 1'b0;
          ovf_d[i]     = 1'b0;
        end else if (!enable[i]) begin
          cnt_d[i]     = start_v[i];
          clk_out_d[i] = 1'b0;
          ovf_d[i]     = 1'b0;
          if (pend_q[i]) begin
            act_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
          end
        end else if (cnt_q[i] >= act_q[i]) begin
          // Half-cycle complete: toggle, and only now adopt a new half-period.
          clk_out_d[i] = ~clk_out_q[i];
          cnt_d[i]     = '0;
          ovf_d[i]     = 1'b1;
          if (pend_q[i]) begin
            act_d[i]  = shd_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = sum[i][W] ? {W{1'b1}} : sum[i][W-1:0];
          ovf_d[i] = 1'b0;
        end
        // A load in a toggle cycle lands in the shadow and waits for the next toggle.
        if (load[i]) begin
          shd_d[i]  = half_period[i*W +: W];
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      pend_q    <= '0;
      clk_out_q <= '0;
      ovf_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      armed_q   <= armed_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
      end
    end
  end

  assign clk_out  = clk_out_q;
  assign overflow = ovf_q;
  assign pending  = pend_q;

endmodule
